// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO drain stream block.
//   DEF_DATA_W : default byte width (matches the upstream FIFO)
//   BUF_DEPTH  : output skid buffer depth
//   state_t    : drain FSM states
//   beat_w()   : width of a beat counter for an n-beat packet (at least 1)
package fifo_stream_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int BUF_DEPTH  = 3;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  function automatic int beat_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_buf3.sv
// 3-entry circular output buffer.
//   clk, rst : clock, async active-low reset
//   wr/wdata : push a byte at the tail
//   pop      : drop the head (ignored when empty)
//   flush    : empty the buffer, pointers back to entry 0
//   occ      : number of held bytes (0..3)
//   head     : byte at the head position
module stream_buf3 import fifo_stream_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);
  logic [BUF_DEPTH-1:0][DATA_W-1:0] mem;
  logic [1:0] wp, rp;
  logic       do_pop;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop = pop & (occ != 2'd0);
  assign head   = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wdata;
        wp      <= nxt(wp);
      end
      if (do_pop) rp <= nxt(rp);
      // Simultaneous write and pop is legal at any occupancy; the read-issue
      // logic upstream never lets a write land on a full buffer without a pop.
      occ <= occ + 2'(wr) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/fifo_drain_stream.sv
// Read-side consumer for the 8-bit synchronous FIFO. Pops bytes (1-cycle read
// latency) and re-presents them as a valid/ready stream framed into PKT_LEN
// beat packets, counting completed packets.
//   clk, rst          : clock, async active-low reset
//   en                : issue FIFO reads while high
//   flush             : drop buffered and in-flight bytes, restart at beat 0
//   fifo_empty/rd_en/dout : FIFO read interface
//   m_valid/ready/data/last : output stream
//   pkt_count         : completed packets (wraps)
//   busy              : buffer or in-flight read non-empty
module fifo_drain_stream import fifo_stream_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              busy
);
  localparam int BW = beat_w(PKT_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  state_t        state;
  logic          inflight;
  logic [1:0]    occ;
  logic [BW-1:0] beat;
  logic          hs;

  // Issue a read only when the buffer can absorb it even with no pop, so
  // there is no combinational path from m_ready to fifo_rd_en.
  assign fifo_rd_en = rst & en & ~flush & ~fifo_empty &
                      (({1'b0, occ} + {2'b0, inflight}) < 3'(BUF_DEPTH));

  assign m_valid = (occ != 2'd0);
  assign busy    = m_valid | inflight;
  // Beat counter tracks the beat index of the buffer head.
  assign m_last  = m_valid & (beat == LAST_BEAT);
  assign hs      = m_valid & m_ready & ~flush;

  stream_buf3 #(.DATA_W(DATA_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (inflight & ~flush),
    .wdata (fifo_dout),
    .pop   (m_valid & m_ready),
    .flush (flush),
    .occ   (occ),
    .head  (m_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inflight <= 1'b0;
    else      inflight <= fifo_rd_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat      <= '0;
      pkt_count <= '0;
    end else if (flush) begin
      beat <= '0;
    end else if (hs) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
      if (m_last) pkt_count <= pkt_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else if (flush) state <= en ? RUN : IDLE;
    else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= busy ? STOP : IDLE;
        STOP:    if (en) state <= RUN;
                 else if (!busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_drain_stream.sv
// Bench for fifo_drain_stream: a queue-based FIFO model feeds the DUT, and a
// queue of popped-but-undelivered bytes predicts the stream, framing and flags.
module tb_fifo_drain_stream;
  localparam int PKT_LEN = 16;

  logic clk = 0, rst = 1, en = 0, flush = 0, fifo_empty = 1, m_ready = 0;
  logic [7:0] fifo_dout = 0;
  logic fifo_rd_en, m_valid, m_last, busy;
  logic [7:0] m_data;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  fifo_drain_stream #(.DATA_W(8), .PKT_LEN(PKT_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .pkt_count(pkt_count), .busy(busy)
  );

  int tests = 0, fails = 0;
  logic [7:0] fq[$];   // FIFO contents
  logic [7:0] exq[$];  // bytes popped from FIFO, not yet delivered
  bit pend;
  int rx_beat, pkt_exp, rd_pulses, rx_cnt, lim;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exq.delete();
    pend = 0; rx_beat = 0; pkt_exp = 0;
  endtask

  task automatic preload(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) fq.push_back(rnd ? 8'($urandom) : 8'(base + i));
  endtask

  task automatic tick(input bit e, input bit r, input bit f, input bit fe);
    bit infl;
    logic [7:0] b;
    @(posedge clk); #1;
    infl = pend;
    if (pend) begin
      b = (fq.size() > 0) ? fq.pop_front() : 8'hEE;
      fifo_dout = b;
      exq.push_back(b);
    end
    fifo_empty = fe || (fq.size() == 0);
    en = e; m_ready = r; flush = f;
    #1;
    chk("rd_en", 32'(fifo_rd_en), 32'(rst && e && !f && !fifo_empty && exq.size() < 3));
    chk("busy", 32'(busy), 32'(exq.size() > 0));
    chk("m_valid", 32'(m_valid), 32'((int'(exq.size()) - int'(infl)) > 0));
    chk("pkt_count", 32'(pkt_count), 32'(pkt_exp[15:0]));
    if (m_valid && exq.size() > int'(infl)) begin
      chk("m_data", 32'(m_data), 32'(exq[0]));
      chk("m_last", 32'(m_last), 32'(rx_beat == PKT_LEN - 1));
    end
    pend = fifo_rd_en;
    if (fifo_rd_en) rd_pulses++;
    if (f) begin
      exq.delete();
      rx_beat = 0;
    end else if (m_valid && m_ready && exq.size() > 0) begin
      void'(exq.pop_front());
      rx_cnt++;
      if (rx_beat == PKT_LEN - 1) begin pkt_exp++; rx_beat = 0; end
      else rx_beat++;
    end
  endtask

  // Async reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #1 rst = 0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    model_reset();
    fq.delete();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    #1 rst = 1;
    rx_cnt = 0; rd_pulses = 0;
  endtask

  initial begin
    do_reset();

    // 1: reset with two bytes buffered
    preload(8, 0, 0);
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    chk("t1_busy_before_rst", 32'(busy), 1);
    do_reset();

    // 2: full-rate packet
    preload(16, 0, 0);
    for (int i = 0; i < 20; i++) tick(1, 1, 0, 0);
    chk("t2_rx", rx_cnt, 16);
    chk("t2_rd_pulses", rd_pulses, 16);
    chk("t2_pkt", 32'(pkt_count), 1);
    do_reset();

    // 3: stalled downstream
    preload(8, 0, 0);
    for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);
    chk("t3_rd_pulses", rd_pulses, 3);
    chk("t3_hold_data", 32'(m_data), 0);
    chk("t3_hold_valid", 32'(m_valid), 1);
    lim = 0;
    while (rx_cnt < 8 && lim < 40) begin tick(1, 1, 0, 0); lim++; end
    chk("t3_rx", rx_cnt, 8);
    do_reset();

    // 4: empty flag toggling every 2 cycles
    preload(24, 0, 1);
    for (int i = 0; i < 100; i++) tick(1, 1, 0, 1'((i / 2) % 2));
    chk("t4_rx", rx_cnt, 24);
    do_reset();

    // 5: pause after beat 5, packet continues afterwards
    preload(16, 8'h50, 0);
    lim = 0;
    while (rx_cnt < 6 && lim < 40) begin tick(1, 1, 0, 0); lim++; end
    lim = 0;
    do begin tick(0, 1, 0, 0); lim++; end while (busy && lim < 20);
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_pkt_mid", 32'(pkt_count), 0);
    lim = 0;
    while (rx_cnt < 16 && lim < 40) begin tick(1, 1, 0, 0); lim++; end
    tick(1, 1, 0, 0);
    chk("t5_rx", rx_cnt, 16);
    chk("t5_pkt", 32'(pkt_count), 1);
    do_reset();

    // 6: flush with buffer and an in-flight read
    preload(40, 0, 0);
    lim = 0;
    while (rx_cnt < 5 && lim < 40) begin tick(1, 1, 0, 0); lim++; end
    lim = 0;
    do begin tick(1, 0, 0, 0); lim++; end while (!(exq.size() == 2 && pend) && lim < 10);
    chk("t6_setup", 32'(exq.size() == 2 && pend), 1);
    tick(1, 0, 1, 0);
    tick(1, 0, 0, 0);
    chk("t6_valid_after_flush", 32'(m_valid), 0);
    chk("t6_pkt_kept", 32'(pkt_count), 0);
    for (int i = 0; i < 45; i++) tick(1, 1, 0, 0);
    chk("t6_pkt", 32'(pkt_count), 2);
    do_reset();

    // randomized traffic
    preload(300, 0, 1);
    for (int i = 0; i < 800; i++)
      tick(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 5) == 0);
    lim = 0;
    while ((fq.size() != 0 || busy) && lim < 600) begin tick(1, 1, 0, 0); lim++; end
    chk("rand_drained", 32'(fq.size() == 0 && !busy), 1);
    chk("rand_pkt", 32'(pkt_count), 32'(pkt_exp[15:0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
